eth_rx_frame_fifo: RTL and testbench
====================================

Name: eth_rx_frame_fifo

Overview:
Store-and-forward RX frame buffer placed directly downstream of the Ethernet framing/address-filter stage. It absorbs the filtered 8-bit AXIS byte stream, which has no backpressure, and commits a frame to the output only when its last byte arrives with tuser=0 (good FCS). It discards errored, oversized and overflowing frames without emitting any of their bytes. The output is a backpressured AXIS master toward the DMA or the SoC.

Parameters:
DEPTH, 4096, buffer capacity in bytes; power of two, at least 2*MAX_FRAME.
MAX_FRAME, 1522, maximum accepted frame length in bytes; longer frames are dropped.
CNT_W, 16, width of the saturating statistic counters.

Ports:
clk_i  in  1  system clock (125 MHz domain of the framing stage)
rst_ni  in  1  reset, synchronous and active-low
s_tdata_i  in  8  input byte from the framing stage
s_tvalid_i  in  1  input byte valid; no ready exists, every valid byte is consumed
s_tlast_i  in  1  last byte of frame
s_tuser_i  in  1  frame error flag, meaningful only with s_tlast_i
m_tdata_o  out  8  output byte
m_tvalid_o  out  1  output valid
m_tready_i  in  1  output ready
m_tlast_o  out  1  last byte of output frame
frames_ok_o  out  CNT_W  committed frames, saturating
drop_err_o  out  CNT_W  frames dropped for tuser=1, saturating
drop_ovf_o  out  CNT_W  frames dropped for buffer full or length > MAX_FRAME, saturating
fill_o  out  $clog2(DEPTH)+1  committed bytes not yet read

Behaviour:
- Reset: synchronous; clk_i with rst_ni=0 clears all pointers, counters and outputs. m_tvalid_o=0, m_tdata_o=0, m_tlast_o=0, counters=0, fill_o=0. Write FSM enters SYNC.
- Storage: DEPTH x 9 bits ({tlast, data}), one write port, combinational read port.
- Pointers: wr_ptr (speculative), cm_ptr (commit), rd_ptr. Each is $clog2(DEPTH)+1 bits and wraps naturally. fill_o = cm_ptr - rd_ptr.
- Free space = DEPTH - (wr_ptr - rd_ptr).
- Write FSM, evaluated on each s_tvalid_i=1 beat:
  - SYNC: discard the byte. On tlast go to IDLE. This prevents committing a partial frame after a mid-frame reset release.
  - IDLE/ACTIVE: if free space = 0 or the byte count would exceed MAX_FRAME, do not write. Set wr_ptr <= cm_ptr. If the beat is not tlast go to DROP; if it is tlast stay IDLE. Either way increment drop_ovf_o.
  - IDLE/ACTIVE, otherwise: write the byte at wr_ptr and increment wr_ptr and the length counter.
    - tlast with tuser=0: cm_ptr <= wr_ptr+1, increment frames_ok_o, go to IDLE.
    - tlast with tuser=1: wr_ptr <= cm_ptr, increment drop_err_o, go to IDLE.
    - Non-last byte: go to ACTIVE.
  - DROP: discard bytes until tlast, then go to IDLE. No further counter increment for that frame.
- s_tvalid_i=0 beats leave state unchanged. Gaps inside a frame are tolerated.
- Commit latency: a good tlast written in cycle N sets m_tvalid_o=1 in cycle N+1 at the earliest.
- Read side:
  - m_tvalid_o = (rd_ptr != cm_ptr).
  - m_tdata_o and m_tlast_o come from mem[rd_ptr]. Both are forced to 0 when m_tvalid_o=0.
  - rd_ptr increments on m_tvalid_o & m_tready_i.
  - Output data stays stable while stalled.
  - Only committed bytes are visible, so an output frame is never aborted.
- Simultaneous write and read: free space is computed from the current rd_ptr. A read in the same cycle does not free space for that write.
- Commit and rollback touch only wr_ptr and cm_ptr, never rd_ptr, so a read in the same cycle is unaffected.
- Counters saturate at all-ones.
- Zero-length frames cannot occur: tlast always carries a byte.

Decomposition:
- Package eth_rx_fifo_pkg:
  - wr_state_e enum {SYNC, IDLE, ACTIVE, DROP}.
  - Entry struct {logic last; logic [7:0] data}.
- Sub-module eth_sat_counter (parameter W; inc_i; cnt_o). Instantiated three times.
- Buffer array is inline.

Test Plan:
1. Reset, then one 64-byte frame with tuser=0 and m_tready_i=1. Expect m_tvalid_o rising the cycle after tlast, 64 bytes in order, m_tlast_o on byte 64, frames_ok_o=1, fill_o back to 0.
2. A 60-byte frame with tuser=1 on tlast, followed by a good 70-byte frame. Expect only the 70 bytes output, drop_err_o=1, frames_ok_o=1.
3. DEPTH=4096 with m_tready_i=0. Send good 1500-byte frames back to back. Expect frames 1 and 2 committed (fill_o=3000) and frame 3 dropped (drop_ovf_o=1). Then raise ready: exactly 3000 bytes out.
4. A 1600-byte frame (exceeds MAX_FRAME=1522), then a 100-byte good frame. Expect drop_ovf_o=1, no bytes of the long frame output, and the 100-byte frame delivered intact.
5. Assert rst_ni low for 1 cycle mid-frame (byte 30 of 80), then continue the stream, then send a 64-byte good frame. Expect the remaining 50 bytes discarded (SYNC) and only the 64-byte frame output.
6. Random m_tready_i toggling during a 2-frame readout. Expect m_tdata_o and m_tlast_o stable while valid and not ready, and byte order and boundaries preserved.

Source files
------------

// File: rtl/eth_rx_fifo_pkg.sv
// Shared types for the Ethernet RX store-and-forward frame FIFO.
package eth_rx_fifo_pkg;

  // Write-side frame tracking states.
  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    ACTIVE,
    DROP
  } wr_state_e;

  // One buffer entry: the byte plus its end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating event counter that stops at all-ones.
module eth_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count up on each event but hold once the counter is saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: only good, complete frames reach the output.
module eth_rx_frame_fifo
  import eth_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int MAX_FRAME = 1522,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               s_tdata_i,
  input  logic                     s_tvalid_i,
  input  logic                     s_tlast_i,
  input  logic                     s_tuser_i,
  output logic [7:0]               m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     m_tlast_o,
  output logic [CNT_W-1:0]         frames_ok_o,
  output logic [CNT_W-1:0]         drop_err_o,
  output logic [CNT_W-1:0]         drop_ovf_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  entry_t    mem_q [DEPTH];
  entry_t    rd_entry;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] len_q, len_d;
  wr_state_e     state_q, state_d;

  logic [PW-1:0] used;
  logic          full;
  logic          too_long;
  logic          wr_en;
  logic          inc_ok;
  logic          inc_err;
  logic          inc_ovf;

  // Space check uses the speculative write pointer against the pre-read rd_ptr.
  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PW'(DEPTH));
  assign too_long = (len_q >= PW'(MAX_FRAME));

  // Write FSM: append bytes speculatively, then commit or roll back at tlast.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    len_d    = len_q;
    wr_en    = 1'b0;
    inc_ok   = 1'b0;
    inc_err  = 1'b0;
    inc_ovf  = 1'b0;
    if (s_tvalid_i) begin
      case (state_q)
        SYNC: begin
          if (s_tlast_i) state_d = IDLE;
        end
        IDLE, ACTIVE: begin
          if (full || too_long) begin
            wr_ptr_d = cm_ptr_q;
            len_d    = '0;
            inc_ovf  = 1'b1;
            state_d  = s_tlast_i ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = len_q + PW'(1);
            state_d  = ACTIVE;
            if (s_tlast_i) begin
              len_d   = '0;
              state_d = IDLE;
              if (!s_tuser_i) begin
                cm_ptr_d = wr_ptr_q + PW'(1);
                inc_ok   = 1'b1;
              end else begin
                wr_ptr_d = cm_ptr_q;
                inc_err  = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (s_tlast_i) state_d = IDLE;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Read side: only committed bytes are visible; outputs are zero when idle.
  always_comb begin
    rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
    m_tvalid_o = (rd_ptr_q != cm_ptr_q);
    m_tdata_o  = m_tvalid_o ? rd_entry.data : 8'h00;
    m_tlast_o  = m_tvalid_o ? rd_entry.last : 1'b0;
    rd_ptr_d   = rd_ptr_q;
    if (m_tvalid_o && m_tready_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer, length and FSM registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= SYNC;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
    end
  end

  // Buffer write port; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{last: s_tlast_i, data: s_tdata_i};
    end
  end

  assign fill_o = cm_ptr_q - rd_ptr_q;

  eth_sat_counter #(.W(CNT_W)) u_cnt_ok (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (inc_ok),
    .cnt_o  (frames_ok_o)
  );

  eth_sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (inc_err),
    .cnt_o  (drop_err_o)
  );

  eth_sat_counter #(.W(CNT_W)) u_cnt_ovf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (inc_ovf),
    .cnt_o  (drop_ovf_o)
  );

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo with a queue-based frame model.
module tb_eth_rx_frame_fifo;

  localparam int DEPTH     = 4096;
  localparam int MAX_FRAME = 1522;
  localparam int CNT_W     = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] drop_err;
  logic [CNT_W-1:0] drop_ovf;
  logic [$clog2(DEPTH):0] fill;

  int  total;
  int  bad;
  bit  check_en;
  bit  rand_rdy;
  int  out_bytes;

  // Model state: committed-but-unread bytes and the frame being received.
  logic [8:0] exp_q[$];
  logic [8:0] cur_q[$];
  int  m_mode;
  int  m_ok;
  int  m_err;
  int  m_ovf;
  bit  do_read;
  bit  full_now;

  // Stall tracking for output stability.
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  eth_rx_frame_fifo #(
    .DEPTH     (DEPTH),
    .MAX_FRAME (MAX_FRAME),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s_tdata_i   (s_tdata),
    .s_tvalid_i  (s_tvalid),
    .s_tlast_i   (s_tlast),
    .s_tuser_i   (s_tuser),
    .m_tdata_o   (m_tdata),
    .m_tvalid_o  (m_tvalid),
    .m_tready_i  (m_tready),
    .m_tlast_o   (m_tlast),
    .frames_ok_o (frames_ok),
    .drop_err_o  (drop_err),
    .drop_ovf_o  (drop_ovf),
    .fill_o      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_stimulus(input int len, input bit err, input int gap_pct,
                                input bit pattern, input bit with_last);
    for (int i = 0; i < len; i++) begin
      while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = pattern ? 8'(8'hA0 + i) : 8'($urandom);
      s_tlast  = with_last && (i == len - 1);
      s_tuser  = s_tlast ? err : 1'($urandom_range(0, 1));
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((m_tvalid || fill != 0) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: drain timeout, fill=%0d", name, fill);
    end
  endtask

  // Reference model: frame-level rules applied with queues at each clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      m_mode = 0;
      m_ok   = 0;
      m_err  = 0;
      m_ovf  = 0;
    end else begin
      do_read  = (exp_q.size() != 0) && m_tready;
      full_now = (exp_q.size() + cur_q.size()) >= DEPTH;
      if (do_read) void'(exp_q.pop_front());
      if (s_tvalid) begin
        if (m_mode == 0) begin
          if (s_tlast) m_mode = 1;
        end else if (m_mode == 2) begin
          if (s_tlast) m_mode = 1;
        end else begin
          if (full_now || cur_q.size() >= MAX_FRAME) begin
            cur_q.delete();
            if (m_ovf != 65535) m_ovf++;
            m_mode = s_tlast ? 1 : 2;
          end else begin
            cur_q.push_back({s_tlast, s_tdata});
            if (s_tlast) begin
              if (!s_tuser) begin
                foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
                if (m_ok != 65535) m_ok++;
              end else begin
                if (m_err != 65535) m_err++;
              end
              cur_q.delete();
            end
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model on every cycle, away from the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_bytes  = 0;
      prev_stall = 1'b0;
    end else if (check_en) begin
      check_output("valid", m_tvalid, exp_q.size() != 0);
      check_output("data", m_tdata, exp_q.size() != 0 ? int'(exp_q[0][7:0]) : 0);
      check_output("last", m_tlast, exp_q.size() != 0 ? int'(exp_q[0][8]) : 0);
      check_output("fill", fill, exp_q.size());
      check_output("frames_ok", frames_ok, m_ok);
      check_output("drop_err", drop_err, m_err);
      check_output("drop_ovf", drop_ovf, m_ovf);
      if (prev_stall) begin
        check_output("stall_valid", m_tvalid, 1);
        check_output("stall_data", m_tdata, prev_data);
        check_output("stall_last", m_tlast, prev_last);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (m_tvalid && m_tready) out_bytes++;
    end
  end

  initial begin
    int l1;
    int l2;
    int base;
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    rand_rdy = 1'b0;
    rst_n    = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    tick();
    tick();
    check_output("rst_valid", m_tvalid, 0);
    check_output("rst_data", m_tdata, 0);
    check_output("rst_fill", fill, 0);
    check_output("rst_ok", frames_ok, 0);
    check_output("rst_ovf", drop_ovf, 0);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // A lone tlast beat moves the writer out of its post-reset sync state.
    apply_stimulus(1, 1'b0, 0, 1'b1, 1'b1);
    tick();
    check_output("sync_fill", fill, 0);
    check_output("sync_ok", frames_ok, 0);

    $display("[TB] test 1: single good 64-byte frame");
    apply_stimulus(64, 1'b0, 0, 1'b1, 1'b1);
    check_output("t1_valid_rise", m_tvalid, 1);
    check_output("t1_first_byte", m_tdata, 8'hA0);
    drain("t1");
    check_output("t1_ok", frames_ok, 1);
    check_output("t1_fill", fill, 0);
    check_output("t1_bytes", out_bytes, 64);

    $display("[TB] test 2: errored frame then good frame");
    apply_stimulus(60, 1'b1, 0, 1'b0, 1'b1);
    apply_stimulus(70, 1'b0, 0, 1'b0, 1'b1);
    drain("t2");
    check_output("t2_err", drop_err, 1);
    check_output("t2_ok", frames_ok, 2);
    check_output("t2_bytes", out_bytes, 134);

    $display("[TB] test 3: buffer overflow with stalled output");
    m_tready = 1'b0;
    repeat (3) apply_stimulus(1500, 1'b0, 0, 1'b0, 1'b1);
    tick();
    check_output("t3_fill", fill, 3000);
    check_output("t3_ovf", drop_ovf, 1);
    check_output("t3_ok", frames_ok, 4);
    m_tready = 1'b1;
    drain("t3");
    check_output("t3_bytes", out_bytes, 3134);

    $display("[TB] test 4: oversized frame then good frame");
    apply_stimulus(1600, 1'b0, 0, 1'b0, 1'b1);
    apply_stimulus(100, 1'b0, 0, 1'b0, 1'b1);
    drain("t4");
    check_output("t4_ovf", drop_ovf, 2);
    check_output("t4_ok", frames_ok, 5);
    check_output("t4_bytes", out_bytes, 3234);

    $display("[TB] test 5: reset mid-frame");
    apply_stimulus(30, 1'b0, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    apply_stimulus(50, 1'b0, 0, 1'b1, 1'b1);
    tick();
    check_output("t5_fill_sync", fill, 0);
    apply_stimulus(64, 1'b0, 0, 1'b0, 1'b1);
    drain("t5");
    check_output("t5_ok", frames_ok, 1);
    check_output("t5_ovf", drop_ovf, 0);
    check_output("t5_err", drop_err, 0);
    check_output("t5_bytes", out_bytes, 64);

    $display("[TB] test 6: random ready during two-frame readout");
    l1 = $urandom_range(40, 300);
    l2 = $urandom_range(40, 300);
    m_tready = 1'b0;
    apply_stimulus(l1, 1'b0, 20, 1'b0, 1'b1);
    apply_stimulus(l2, 1'b0, 20, 1'b0, 1'b1);
    rand_rdy = 1'b1;
    drain("t6");
    check_output("t6_ok", frames_ok, 3);
    check_output("t6_bytes", out_bytes, 64 + l1 + l2);

    $display("[TB] test 7: random frames, errors and backpressure");
    base = out_bytes;
    for (int f = 0; f < 40; f++) begin
      apply_stimulus((f == 0) ? 1 : $urandom_range(1, 200),
                     ($urandom_range(0, 7) == 0), 25, 1'b0, 1'b1);
    end
    drain("t7");
    check_output("t7_fill", fill, 0);
    check_output("t7_ok_consistent", frames_ok, m_ok);
    if (out_bytes <= base) begin
      total++;
      bad++;
      $display("[TB] FAIL t7_progress: got %0d bytes expected more than %0d", out_bytes, base);
    end else begin
      total++;
    end

    rand_rdy = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
